// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - instruction fetch stage with prefetch FIFO and redirect
//
// Purpose: owns the fetch PC and drives the combinational instruction ROM.
// Each returned word is captured with its PC into a small prefetch FIFO.
// The FIFO head goes to decode over a valid/ready handshake. A redirect
// flushes the FIFO and reloads the PC.
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   When it is defined, a misaligned redirect enters TRAP and delivers one
//   NOP entry flagged through if_misalign.
//   When it is not defined, the low two redirect bits are masked off.
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   synchronous active-high reset
//   rom_addr       out  ROM byte address = fetch_pc[ADDR_W-1:0]
//   rom_inst       in   ROM word for rom_addr, same cycle
//   redirect_valid in   load redirect_pc and flush the FIFO
//   redirect_pc    in   new fetch address
//   if_valid       out  FIFO head valid
//   if_ready       in   decode accepts the head
//   if_inst        out  head instruction (NOP when empty)
//   if_pc          out  head PC
//   if_misalign    out  head entry is a misaligned-redirect trap (macro only)

module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          ADDR_W     = 12,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_inst,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [31:0]       if_inst,
  output logic [31:0]       if_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic              if_misalign
`endif
);

  localparam int              PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int              CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [31:0]     NOP     = 32'h0000_0013;

  typedef enum logic {RUN = 1'b0, TRAP = 1'b1} state_e;

  state_e            state_q;
  logic [31:0]       fetch_pc_q;
  logic [CNT_W-1:0]  count_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [31:0]       pc_mem_q   [FIFO_DEPTH];
  logic [31:0]       inst_mem_q [FIFO_DEPTH];

  logic        pop;
  logic        room;
  logic        push;
  logic [31:0] push_inst;
  logic [31:0] redir_target;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic mis_mem_q [FIFO_DEPTH];
  logic trap_armed_q;
  logic redir_mis;

  assign redir_mis    = |redirect_pc[1:0];
  // A misaligned target is kept unmasked so that the trap entry reports it exactly.
  assign redir_target = redir_mis ? redirect_pc : {redirect_pc[31:2], 2'b00};
`else
  logic unused_redir_lsb;

  assign unused_redir_lsb = ^redirect_pc[1:0];
  assign redir_target     = {redirect_pc[31:2], 2'b00};
`endif

  assign pop  = if_valid & if_ready;
  // A slot frees up this cycle if the FIFO is not full or the head is leaving.
  assign room = (count_q < DEPTH_C) | pop;

  always_comb begin
    push      = 1'b0;
    push_inst = rom_inst;
    if (!reset && !redirect_valid && room) begin
      if (state_q == RUN) begin
        push = 1'b1;
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      // In TRAP the fetch stage emits one flagged NOP and then stalls.
      else if (trap_armed_q) begin
        push      = 1'b1;
        push_inst = NOP;
      end
`endif
    end
  end

  assign rom_addr = fetch_pc_q[ADDR_W-1:0];
  assign if_valid = (count_q != '0);
  assign if_inst  = if_valid ? inst_mem_q[rd_ptr_q] : NOP;
  assign if_pc    = pc_mem_q[rd_ptr_q];
`ifdef FETCH_MISALIGN_TRAP_EN
  assign if_misalign = if_valid & mis_mem_q[rd_ptr_q];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_mem_q[i]   <= RESET_PC;
        inst_mem_q[i] <= NOP;
`ifdef FETCH_MISALIGN_TRAP_EN
        mis_mem_q[i]  <= 1'b0;
`endif
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      trap_armed_q <= 1'b0;
`endif
    end else if (redirect_valid) begin
      // Flush: anything in flight, including a pop this cycle, is dropped.
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fetch_pc_q <= redir_target;
`ifdef FETCH_MISALIGN_TRAP_EN
      state_q      <= redir_mis ? TRAP : RUN;
      trap_armed_q <= redir_mis;
`else
      state_q    <= RUN;
`endif
    end else begin
      if (push) begin
        pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
        inst_mem_q[wr_ptr_q] <= push_inst;
`ifdef FETCH_MISALIGN_TRAP_EN
        mis_mem_q[wr_ptr_q]  <= (state_q == TRAP);
        if (state_q == TRAP) begin
          trap_armed_q <= 1'b0;
        end
`endif
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (state_q == RUN) begin
          fetch_pc_q <= fetch_pc_q + 32'd4;
        end
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - randomized self-checking bench for inst_fetch_unit

module tb_inst_fetch_unit;

  localparam int          ADDR_W   = 12;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_inst;
  logic              redirect_valid = 1'b0;
  logic [31:0]       redirect_pc = '0;
  logic              if_valid;
  logic              if_ready = 1'b0;
  logic [31:0]       if_inst;
  logic [31:0]       if_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic              if_misalign;
`endif

  always #5 clk = ~clk;

  // ROM contents: each word is its own byte address plus 0x1000.
  assign rom_inst = 32'(rom_addr) + 32'h0000_1000;

  inst_fetch_unit #(
    .RESET_PC  (RESET_PC),
    .ADDR_W    (ADDR_W),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rom_addr      (rom_addr),
    .rom_inst      (rom_inst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_inst       (if_inst),
    .if_pc         (if_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .if_misalign   (if_misalign)
`endif
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        mis;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] mpc    = RESET_PC;
  bit          mtrap  = 1'b0;
  bit          marmed = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk_eq("if_valid", 32'(if_valid), 32'(mq.size() != 0));
    chk_eq("rom_addr", 32'(rom_addr), 32'(mpc[ADDR_W-1:0]));
    if (mq.size() != 0) begin
      chk_eq("if_pc", if_pc, mq[0].pc);
      chk_eq("if_inst", if_inst, mq[0].inst);
`ifdef FETCH_MISALIGN_TRAP_EN
      chk_eq("if_misalign", 32'(if_misalign), 32'(mq[0].mis));
`endif
    end else begin
      chk_eq("if_inst_empty", if_inst, NOP);
`ifdef FETCH_MISALIGN_TRAP_EN
      chk_eq("if_misalign_empty", 32'(if_misalign), 32'd0);
`endif
    end
  endtask

  // Reference behaviour of one clock edge, expressed on a queue of entries.
  task automatic model_step(input bit rst, input bit rv, input logic [31:0] rpc, input bit rdy);
    bit pop;
    if (rst) begin
      mq.delete();
      mpc    = RESET_PC;
      mtrap  = 1'b0;
      marmed = 1'b0;
    end else if (rv) begin
      mq.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
      if (rpc[1:0] != 2'b00) begin
        mpc    = rpc;
        mtrap  = 1'b1;
        marmed = 1'b1;
      end else begin
        mpc    = rpc & ~32'h3;
        mtrap  = 1'b0;
        marmed = 1'b0;
      end
`else
      mpc = rpc & ~32'h3;
`endif
    end else begin
      pop = (mq.size() != 0) && rdy;
      if (pop) void'(mq.pop_front());
      if (mq.size() < DEPTH) begin
        if (!mtrap) begin
          mq.push_back('{pc: mpc, inst: 32'(mpc[ADDR_W-1:0]) + 32'h1000, mis: 1'b0});
          mpc = mpc + 32'd4;
        end else if (marmed) begin
          mq.push_back('{pc: mpc, inst: NOP, mis: 1'b1});
          marmed = 1'b0;
        end
      end
    end
  endtask

  task automatic cycle(input bit rst, input bit rv, input logic [31:0] rpc, input bit rdy);
    @(negedge clk);
    check_outputs();
    reset          = rst;
    redirect_valid = rv;
    redirect_pc    = rpc;
    if_ready       = rdy;
    model_step(rst, rv, rpc, rdy);
    @(posedge clk);
  endtask

  task automatic run(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, rdy);
  endtask

  initial begin
    logic [31:0] rpc;
    bit          rv;
    bit          rst;

    // Reset state.
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    #1;
    chk_eq("rst_if_valid", 32'(if_valid), 32'd0);
    chk_eq("rst_if_pc", if_pc, RESET_PC);
    chk_eq("rst_if_inst", if_inst, NOP);
    chk_eq("rst_rom_addr", 32'(rom_addr), 32'(RESET_PC[ADDR_W-1:0]));

    // Streaming with decode always ready.
    run(8, 1'b1);

    // Back-pressure saturates the FIFO, then drains without gaps.
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    run(5, 1'b0);
    run(6, 1'b1);

    // Redirect while full and popping.
    run(3, 1'b0);
    cycle(1'b0, 1'b1, 32'h0000_0040, 1'b1);
    run(5, 1'b1);

    // Back-to-back redirects.
    cycle(1'b0, 1'b1, 32'h0000_0100, 1'b1);
    cycle(1'b0, 1'b1, 32'h0000_0200, 1'b1);
    run(5, 1'b1);

    // Reset mid-stream with a full FIFO.
    cycle(1'b0, 1'b1, 32'h0000_0018, 1'b0);
    run(4, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    run(4, 1'b1);

    // Misaligned redirect, then recovery through an aligned redirect.
    cycle(1'b0, 1'b1, 32'h0000_0042, 1'b1);
    run(5, 1'b1);
    cycle(1'b0, 1'b1, 32'h0000_0080, 1'b1);
    run(4, 1'b1);

    // Misaligned redirect held under back-pressure, then re-armed.
    cycle(1'b0, 1'b1, 32'h0000_0101, 1'b0);
    run(3, 1'b0);
    cycle(1'b0, 1'b1, 32'h0000_0203, 1'b0);
    run(3, 1'b1);

    // PC aliasing beyond the ROM size.
    cycle(1'b0, 1'b1, 32'hABCD_EFF8, 1'b1);
    run(6, 1'b1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      rv  = ($urandom_range(0, 9) == 0);
      rpc = $urandom;
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      cycle(rst, rv, rpc, 1'($urandom_range(0, 3) != 0));
    end

    @(negedge clk);
    check_outputs();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Instruction fetch stage directly upstream of the combinational instruction ROM.
- Owns the program counter and drives the ROM byte address. Captures the returned word into a small prefetch FIFO and presents {pc, inst} to decode over a valid/ready handshake.
- Accepts redirects (branch/jump targets) that flush the FIFO and reload the PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 12, ROM byte-address width; upper PC bits are not presented to the ROM.
- FIFO_DEPTH, 2, prefetch FIFO entries; must be a power of two, 2..8.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- rom_addr  output  ADDR_W  byte address to ROM, equal to fetch_pc[ADDR_W-1:0].
- rom_inst  input  32  instruction word returned combinationally by the ROM in the same cycle.
- redirect_valid  input  1  load redirect_pc and flush the FIFO.
- redirect_pc  input  32  new fetch address.
- if_valid  output  1  FIFO head is valid.
- if_ready  input  1  decode accepts the head this cycle.
- if_inst  output  32  instruction at FIFO head.
- if_pc  output  32  PC of the instruction at FIFO head.

Behaviour:
- Clock and reset: single clock `clk`. Reset `reset` is synchronous and active-high.
- Reset values:
  - fetch_pc = RESET_PC; FIFO count = 0; read/write pointers = 0.
  - if_valid = 0; if_inst = 32'h0000_0013 (NOP); if_pc = RESET_PC.
  - rom_addr = RESET_PC[ADDR_W-1:0].
- Pop: pop = if_valid & if_ready.
- Push condition: push = ~reset & ~redirect_valid & (count < FIFO_DEPTH | pop).
  - On push, write {fetch_pc, rom_inst} at the write pointer and set fetch_pc <= fetch_pc + 4.
  - The add is a 32-bit wrapping add; no carry out.
- FIFO is full (count == FIFO_DEPTH) and no pop:
  - No push; fetch_pc holds; rom_addr is stable.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointers: wrap modulo FIFO_DEPTH.
- Outputs:
  - if_valid = (count != 0).
  - if_inst and if_pc are read directly from the head entry.
  - When the FIFO is empty, if_inst = NOP and if_pc = head slot contents.
- Latency: an instruction at address A is presented on if_valid one cycle after rom_addr == A. After reset deassertion, the first if_valid is in cycle 1.
- Redirect (redirect_valid = 1) has highest priority after reset:
  - count <= 0; pointers <= 0; fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - No push that cycle. Any pop that cycle is discarded.
  - The first redirected instruction is valid two cycles after redirect_valid.
- Back-to-back redirects: the last one wins; no push happens between them.
- Reset asserted mid-stream: all state returns to reset values on the next edge, and pending FIFO entries are lost.
- Address range: rom_addr uses only the low ADDR_W bits. A PC beyond the ROM size aliases; this is not flagged.
- Handshake stability: once if_valid = 1, if_inst and if_pc stay stable until pop or redirect.
- FSM (state): two states, RUN and TRAP.
  - TRAP is reachable only with the optional feature enabled.
  - Without it, the state is constantly RUN.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Enabled:
  - Adds output port if_misalign (1 bit) and a per-entry misalign flag.
  - A redirect with redirect_pc[1:0] != 0 moves the FSM RUN->TRAP and loads fetch_pc <= redirect_pc unmasked.
  - In TRAP, exactly one entry is pushed: {redirect_pc, NOP, misalign = 1}. After that, pushes stop and fetch_pc holds.
  - The FSM leaves TRAP only on an aligned redirect (-> RUN) or reset. A misaligned redirect while already in TRAP re-arms the single trap entry.
  - if_misalign reset value is 0, and it is 0 when the FIFO is empty.
- Disabled:
  - No if_misalign port.
  - redirect_pc[1:0] is silently masked to 0; no TRAP state.

Test Plan:
- Reset then if_ready = 1 constantly, ROM model returning addr+32'h1000 -> if_valid first in cycle 1. if_pc sequence 0x0, 0x4, 0x8, with if_inst 0x1000, 0x1004, 0x1008 one per cycle.
- if_ready = 0 for 5 cycles after reset (FIFO_DEPTH = 2) -> count saturates at 2. rom_addr holds at 0x8; if_pc stays 0x0. On if_ready = 1, the output stream is 0x0, 0x4, 0x8 with no gaps and no duplicates.
- Redirect to 0x0000_0040 while the FIFO holds 2 entries and if_ready = 1 -> the popped entry is discarded. if_valid = 0 the next cycle. Two cycles after redirect, if_pc = 0x40, then 0x44.
- Redirect 0x0000_0100 and 0x0000_0200 on consecutive cycles -> the first delivered if_pc is 0x200; 0x100 is never presented.
- Reset asserted while count = 2 and PC = 0x20 -> the next cycle has if_valid = 0 and rom_addr = 0x0. Delivery restarts at if_pc = 0x0.
- Misaligned redirect to 0x0000_0042:
  - Macro on: one entry with if_pc = 0x42, if_inst = 0x13, if_misalign = 1, then if_valid stays 0 until a redirect to 0x80 resumes at 0x80.
  - Macro off: delivery resumes at 0x40.
